// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 16550-compatible UART receive path. Deserialises SIN with
//                16x oversampling, checks parity, framing and break, and
//                buffers characters plus error flags in a first-word
//                fall-through FIFO with trigger, timeout and overrun status.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             PCLK,
    input  logic             reset,
    input  logic             baudpulse,
    input  logic             SIN,
    input  logic [1:0]       wordlen,
    input  logic             stopbits2,
    input  logic             parityen,
    input  logic             evenparity,
    input  logic             stickparity,
    input  logic             fifoen,
    input  logic [1:0]       rxtrig,
    input  logic             fifoclear,
    input  logic             rxread,
    input  logic             lsrread,
    output logic [7:0]       rxdata,
    output logic             rxdr,
    output logic             rxpe,
    output logic             rxfe,
    output logic             rxbi,
    output logic             rxoverrun,
    output logic             rxfifoerr,
    output logic             rxtrigger,
    output logic             rxtimeout,
    output logic [CNT_W-1:0] rxcount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_BREAKWAIT = 3'd5;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic        sin_meta_q, sin_sync_q;
    logic [2:0]  state_q, state_d;
    logic [3:0]  os_cnt_q, os_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_bit_q, par_bit_d;
    logic        pe_q, pe_d;

    logic        push;
    logic [10:0] push_entry;
    logic        is_break;
    logic        exp_par;
    logic [2:0]  last_bit;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [10:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ovr_q, ovr_d;
    logic             fifoen_q;
    logic [9:0]       tmo_q, tmo_d;

    logic             fifo_clr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             overwrite;
    logic             ovr_set;
    logic [PTR_W-1:0] wr_addr;
    logic [10:0]      head;
    logic             head_err;
    logic             entry_err;
    logic [3:0]       charbits;
    logic [9:0]       tmo_limit;
    logic [CNT_W-1:0] trig_level;

    assign last_bit = 3'd4 + {1'b0, wordlen};
    assign exp_par  = stickparity ? ~evenparity : (^data_q ^ ~evenparity);

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge PCLK) begin
        if (reset) begin
            sin_meta_q <= 1'b1;
            sin_sync_q <= 1'b1;
        end else begin
            sin_meta_q <= SIN;
            sin_sync_q <= sin_meta_q;
        end
    end

    // Receiver next-state: all decisions are taken on baudpulse cycles only
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        pe_d       = pe_q;
        push       = 1'b0;
        push_entry = '0;
        is_break   = 1'b0;
        if (baudpulse) begin
            case (state_q)
                S_IDLE: begin
                    if (!sin_sync_q) begin
                        state_d   = S_START;
                        os_cnt_d  = 4'd0;
                        data_d    = 8'h00;
                        par_bit_d = 1'b0;
                        pe_d      = 1'b0;
                    end
                end
                S_START: begin
                    if (os_cnt_q == 4'd7) begin
                        // Mid-bit check rejects glitches shorter than half a bit
                        if (sin_sync_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            bit_idx_d = 3'd0;
                            os_cnt_d  = 4'd0;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        data_d[bit_idx_q] = sin_sync_q;
                        if (bit_idx_q == last_bit) begin
                            state_d = parityen ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        par_bit_d = sin_sync_q;
                        pe_d      = (sin_sync_q != exp_par);
                        state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        // par_bit_q stays 0 when parity is disabled
                        is_break   = (data_q == 8'h00) && !par_bit_q && !sin_sync_q;
                        push       = 1'b1;
                        push_entry = {is_break, ~sin_sync_q, pe_q,
                                      is_break ? 8'h00 : data_q};
                        state_d    = is_break ? S_BREAKWAIT : S_IDLE;
                    end
                end
                S_BREAKWAIT: begin
                    if (sin_sync_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Receiver state registers
    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            os_cnt_q  <= 4'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign fifo_clr  = fifoclear | (fifoen ^ fifoen_q);
    assign empty     = (count_q == '0);
    assign full      = fifoen ? (count_q == CNT_W'(FIFO_DEPTH)) : !empty;
    assign do_pop    = rxread & !empty & !fifo_clr;
    // A push into a full buffer only lands if a pop frees a slot the same cycle
    assign do_push   = push & !fifo_clr & (!full | do_pop);
    assign ovr_set   = push & !fifo_clr & full & !do_pop;
    // Holding-register mode replaces the unread character instead of dropping it
    assign overwrite = ovr_set & !fifoen;
    assign wr_addr   = overwrite ? rd_ptr_q : wr_ptr_q;
    assign head      = mem_q[rd_ptr_q];
    assign head_err  = |head[10:8];
    assign entry_err = |push_entry[10:8];

    assign charbits  = 4'd7 + {2'b00, wordlen} + {3'b000, parityen} + {3'b000, stopbits2};
    assign tmo_limit = {charbits, 6'b000000};

    // Trigger threshold decode
    always_comb begin
        trig_level = CNT_W'(1);
        case (rxtrig)
            2'b00: trig_level = CNT_W'(1);
            2'b01: trig_level = CNT_W'(FIFO_DEPTH / 4);
            2'b10: trig_level = CNT_W'(FIFO_DEPTH / 2);
            2'b11: trig_level = CNT_W'(FIFO_DEPTH - 2);
            default: trig_level = CNT_W'(1);
        endcase
    end

    // FIFO pointer, occupancy, error-count, overrun and timeout next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;

        if (fifo_clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            err_cnt_d = err_cnt_q
                      + CNT_W'(do_push & entry_err)
                      + CNT_W'(overwrite & entry_err)
                      - CNT_W'(do_pop & head_err)
                      - CNT_W'(overwrite & head_err);
        end

        // Set has priority so an overrun in the read cycle is not lost
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (lsrread) begin
            ovr_d = 1'b0;
        end

        if (fifo_clr || do_push || overwrite || do_pop || empty || !fifoen) begin
            tmo_d = 10'd0;
        end else if (baudpulse && (tmo_q < tmo_limit)) begin
            tmo_d = tmo_q + 10'd1;
        end
    end

    // FIFO control registers
    always_ff @(posedge PCLK) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            ovr_q     <= 1'b0;
            fifoen_q  <= 1'b0;
            tmo_q     <= 10'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            ovr_q     <= ovr_d;
            fifoen_q  <= fifoen;
            tmo_q     <= tmo_d;
        end
    end

    // Storage array; contents are don't-care until written, outputs are gated
    always_ff @(posedge PCLK) begin
        if (do_push || overwrite) begin
            mem_q[wr_addr] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rxdata    = empty ? 8'h00 : head[7:0];
    assign rxpe      = !empty & head[8];
    assign rxfe      = !empty & head[9];
    assign rxbi      = !empty & head[10];
    assign rxdr      = !empty;
    assign rxoverrun = ovr_q;
    assign rxfifoerr = (err_cnt_q != '0);
    assign rxtrigger = fifoen ? (count_q >= trig_level) : !empty;
    assign rxtimeout = (tmo_q >= tmo_limit);
    assign rxcount   = count_q;

endmodule
`default_nettype wire
